// File: rtl/threemux_arbiter_pkg.sv
// threemux_arbiter_pkg
//   Shared constants and helpers for the 3-source round-robin mux arbiter.
//   - Source indices: the bit position of each source in REQ/GNT.
//   - Select pairs, ordered {S1, S}, that drive the two-stage source mux.
//   - FSM state encoding.
//   - Helpers that map a one-hot grant to a select pair or a source index.
package threemux_arbiter_pkg;

  // Bit positions in REQ/GNT
  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_D = 2'd2;

  // Select pairs {S1, S}
  localparam logic [1:0] SEL_A    = 2'b11;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_D    = 2'b00;
  localparam logic [1:0] SEL_IDLE = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Select pair for a one-hot grant; anything that is not a single owner
  // maps to the idle pair.
  function automatic logic [1:0] sel_of(input logic [2:0] gnt);
    logic [1:0] sel;
    case (gnt)
      3'b001:  sel = SEL_A;
      3'b010:  sel = SEL_B;
      3'b100:  sel = SEL_D;
      default: sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

  // Source index of a one-hot grant. Only called with a valid one-hot value;
  // the default arm covers D.
  function automatic logic [1:0] idx_of(input logic [2:0] onehot);
    logic [1:0] idx;
    case (onehot)
      3'b001:  idx = SRC_A;
      3'b010:  idx = SRC_B;
      default: idx = SRC_D;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/threemux_arbiter_rr_pick3.sv
// threemux_arbiter_rr_pick3
//   Combinational 3-way round-robin picker. The search starts at the source
//   after last_i and wraps A -> B -> D -> A; the first requesting source that
//   is not excluded wins.
//   Ports:
//     req_i   [2:0]  request lines (bit0=A, bit1=B, bit2=D)
//     excl_i  [2:0]  sources that may not win (the current owner on handover)
//     last_i  [1:0]  index of the most recent owner
//     gnt_o   [2:0]  one-hot winner, 3'b000 when nothing eligible requests
module threemux_arbiter_rr_pick3
  import threemux_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] excl_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o
);

  logic [2:0] masked;
  logic [1:0] order [3];

  always_comb begin
    masked = req_i & ~excl_i;

    // order[0] is the highest-priority candidate for this LAST value
    order = '{SRC_A, SRC_B, SRC_D};
    case (last_i)
      SRC_A:   order = '{SRC_B, SRC_D, SRC_A};
      SRC_B:   order = '{SRC_D, SRC_A, SRC_B};
      default: order = '{SRC_A, SRC_B, SRC_D};
    endcase

    // Walk from lowest to highest priority so the highest-priority
    // eligible source is the last one written.
    gnt_o = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      if (masked[order[k]]) begin
        gnt_o = 3'b001 << order[k];
      end
    end
  end

endmodule

// File: rtl/threemux_arbiter.sv
// threemux_arbiter
//   Round-robin arbiter driving the select lines of the 3-input source mux
//   (sources A, B, D). Produces a registered one-hot grant together with the
//   registered {S1, S} select pair, so the mux selects only move on clk edges.
//   An owner that keeps requesting while others wait is preempted after
//   MAX_HOLD cycles; a sole requester holds indefinitely.
//   Parameters:
//     MAX_HOLD  cycles an owner may keep the mux under contention (1..15)
//     CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//   Ports:
//     clk       system clock, rising edge
//     rst       asynchronous active-high reset
//     EN        0 blocks new grants and preemption; the owner may still release
//     REQ[2:0]  request lines, bit0=A, bit1=B, bit2=D
//     GNT[2:0]  registered one-hot grant, 000 = no owner
//     VALID     registered, high while GNT is nonzero
//     S         first-stage select: 1 = A, 0 = B
//     S1        second-stage select: 1 = first stage, 0 = D
//     HOLD_CNT  cycles the current owner has held the grant, saturating
module threemux_arbiter
  import threemux_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic [2:0]       REQ,
  output logic [2:0]       GNT,
  output logic             VALID,
  output logic             S,
  output logic             S1,
  output logic [CNT_W-1:0] HOLD_CNT
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       pick_gnt;
  logic             owner_req;
  logic             other_req;
  logic             at_limit;

  assign owner_req = |(REQ & gnt_q);
  assign other_req = |(REQ & ~gnt_q);
  assign at_limit  = (cnt_q == HOLD_LAST);

  // gnt_q is 000 in IDLE, so excluding it serves both fresh grants and
  // handovers away from the current owner with one picker.
  threemux_arbiter_rr_pick3 u_pick (
    .req_i  (REQ),
    .excl_i (gnt_q),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        cnt_d = '0;
        if (EN && (REQ != 3'b000)) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
          last_d  = idx_of(pick_gnt);
        end
      end

      GRANT: begin
        if (!owner_req) begin
          if (EN && other_req) begin
            // Release straight into the next owner, no idle bubble
            gnt_d  = pick_gnt;
            last_d = idx_of(pick_gnt);
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
            cnt_d   = '0;
          end
        end else if (EN && other_req && at_limit) begin
          // Preemption: hold budget used up while someone else waits
          gnt_d  = pick_gnt;
          last_d = idx_of(pick_gnt);
          cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        cnt_d   = '0;
      end
    endcase

    // Selects are derived from the next grant so both land in the same flop stage
    sel_d = sel_of(gnt_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      sel_q   <= SEL_IDLE;
      valid_q <= 1'b0;
      last_q  <= SRC_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= |gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT      = gnt_q;
  assign VALID    = valid_q;
  assign S1       = sel_q[1];
  assign S        = sel_q[0];
  assign HOLD_CNT = cnt_q;

endmodule

// File: tb/tb_threemux_arbiter.sv
// tb_threemux_arbiter
//   Randomized and directed stimulus for threemux_arbiter, checked every cycle
//   against a behavioural model (owner index, last owner, hold count) kept in
//   plain integers, plus literal expectations at known points.
module tb_threemux_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             EN  = 1'b0;
  logic [2:0]       REQ = 3'b000;
  logic [2:0]       GNT;
  logic             VALID;
  logic             S;
  logic             S1;
  logic [CNT_W-1:0] HOLD_CNT;

  always #5 clk = ~clk;

  threemux_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .REQ      (REQ),
    .GNT      (GNT),
    .VALID    (VALID),
    .S        (S),
    .S1       (S1),
    .HOLD_CNT (HOLD_CNT)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: owner index (-1 = none, 0=A, 1=B, 2=D), last owner, hold count
  int m_own  = -1;
  int m_last = 2;
  int m_cnt  = 0;

  function automatic bit req_bit(input int j);
    return ((REQ >> j) & 3'b001) != 3'b000;
  endfunction

  // First requesting source after m_last (wrapping), skipping excl
  function automatic int rr_win(input int excl);
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (m_last + k) % 3;
      if (req_bit(j) && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int own, cnt, lst, w;
    if (rst) begin
      m_own  <= -1;
      m_last <= 2;
      m_cnt  <= 0;
    end else begin
      own = m_own;
      cnt = m_cnt;
      lst = m_last;
      if (own < 0) begin
        if (EN && REQ != 3'b000) begin
          w = rr_win(-1);
          own = w; cnt = 0; lst = w;
        end
      end else if (!req_bit(own)) begin
        w = rr_win(own);
        if (EN && w >= 0) begin
          own = w; cnt = 0; lst = w;
        end else begin
          own = -1; cnt = 0;
        end
      end else begin
        w = rr_win(own);
        if (EN && w >= 0 && cnt == MAX_HOLD - 1) begin
          own = w; cnt = 0; lst = w;
        end else if (cnt < CNT_SAT) begin
          cnt = cnt + 1;
        end
      end
      m_own  <= own;
      m_cnt  <= cnt;
      m_last <= lst;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    chk(nm, act, exp);
    $display("check %-14s got %0d want %0d", nm, act, exp);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int exp_gnt;
    exp_gnt = (m_own < 0) ? 0 : (1 << m_own);
    chk("GNT", int'(GNT), exp_gnt);
    chk("VALID", int'(VALID), int'(m_own >= 0));
    chk("S1", int'(S1), int'(m_own == 0 || m_own == 1));
    chk("S", int'(S), int'(m_own == 0));
    chk("HOLD_CNT", int'(HOLD_CNT), m_cnt);
    chk("GNT_ONEHOT", int'($countones(GNT) <= 1), 1);
  end

  initial begin
    repeat (2) @(negedge clk);
    lit("reset_gnt", int'(GNT), 0);
    lit("reset_valid", int'(VALID), 0);
    #1 rst = 1'b0; EN = 1'b1; REQ = 3'b111;

    // Full contention rotation with MAX_HOLD=4
    for (int e = 1; e <= 17; e++) begin
      @(negedge clk);
      case (e)
        1: begin
          lit("e1_gnt", int'(GNT), 1);
          lit("e1_s1", int'(S1), 1);
          lit("e1_s", int'(S), 1);
        end
        4: lit("e4_hold", int'(HOLD_CNT), 3);
        5: begin
          lit("e5_gnt", int'(GNT), 2);
          lit("e5_s1", int'(S1), 1);
          lit("e5_s", int'(S), 0);
          lit("e5_hold", int'(HOLD_CNT), 0);
        end
        9: begin
          lit("e9_gnt", int'(GNT), 4);
          lit("e9_s1", int'(S1), 0);
        end
        13: lit("e13_gnt", int'(GNT), 1);
        17: lit("e17_gnt", int'(GNT), 2);
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of B's grant
    #2 rst = 1'b1;
    #1;
    lit("arst_gnt", int'(GNT), 0);
    lit("arst_valid", int'(VALID), 0);
    lit("arst_s", int'(S), 0);
    lit("arst_s1", int'(S1), 0);
    lit("arst_hold", int'(HOLD_CNT), 0);
    @(negedge clk);
    #1 rst = 1'b0; EN = 1'b1; REQ = 3'b100;

    // Sole requester D for 40 cycles
    repeat (40) @(negedge clk);
    lit("sole_gnt", int'(GNT), 4);
    lit("sole_s1", int'(S1), 0);
    lit("sole_hold_sat", int'(HOLD_CNT), 15);

    // Release handover D -> A, then A -> B
    #1 REQ = 3'b011;
    @(negedge clk);
    lit("rel_to_a", int'(GNT), 1);
    #1 REQ = 3'b010;
    @(negedge clk);
    lit("rel_to_b", int'(GNT), 2);
    lit("rel_hold", int'(HOLD_CNT), 0);

    // Release to idle, then LAST=B gives D priority
    #1 REQ = 3'b000;
    @(negedge clk);
    lit("idle_gnt", int'(GNT), 0);
    lit("idle_valid", int'(VALID), 0);
    #1 REQ = 3'b101;
    @(negedge clk);
    lit("after_b_gnt", int'(GNT), 4);

    // EN gating from IDLE
    #1 REQ = 3'b000;
    @(negedge clk);
    #1 EN = 1'b0; REQ = 3'b001;
    repeat (3) @(negedge clk);
    lit("en0_idle_gnt", int'(GNT), 0);

    // EN dropped while D owns: no preemption
    #1 EN = 1'b1; REQ = 3'b100;
    @(negedge clk);
    lit("en_d_gnt", int'(GNT), 4);
    #1 EN = 1'b0; REQ = 3'b101;
    repeat (10) @(negedge clk);
    lit("en0_keep_gnt", int'(GNT), 4);
    lit("en0_keep_hold", int'(HOLD_CNT), 10);

    // Randomized phase with occasional asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      #1;
      rst = 1'b0;
      EN  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) REQ = 3'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
      end
      @(negedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/threemux_arbiter.md
Name: threemux_arbiter

Overview:
- Round-robin arbiter that owns the select lines of the 3-input 2-bit source mux (sources A, B, D).
- Sits directly upstream of the mux. It converts per-source request lines into a registered one-hot grant plus the S/S1 select pair.
- The selected source stays stable on the mux output F for a bounded number of cycles.
- Guarantees glitch-free, registered selects: S/S1 only change on clk edges.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one source may own the mux while another source is requesting. Legal range 1..15.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- EN  input  1  when 0, no new grant is issued; the current owner is unaffected.
- REQ  input  3  request lines: bit0=A, bit1=B, bit2=D.
- GNT  output  3  one-hot registered grant, same bit order as REQ; 3'b000 = no owner.
- VALID  output  1  high when GNT is nonzero.
- S  output  1  mux first-stage select: 1 = A, 0 = B.
- S1  output  1  mux second-stage select: 1 = first-stage result, 0 = D.
- HOLD_CNT  output  CNT_W  cycles the current owner has held the grant, saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - GNT=000, VALID=0, S=0, S1=0, HOLD_CNT=0.
  - State=IDLE; last-owner pointer LAST=2 (D), so A has first priority after reset.
- Select encoding, registered together with GNT in the same flop stage:
  - A: S1=1, S=1.
  - B: S1=1, S=0.
  - D: S1=0, S=0.
  - Idle: S1=0, S=0, with VALID=0 marking the mux output as don't-care.
- Round-robin order: search starts at (LAST+1) mod 3 and wraps A→B→D→A. The first requesting source wins.
- States: IDLE and GRANT.
- IDLE:
  - If EN=1 and REQ!=0 at edge k, GNT/S/S1/VALID update at edge k, so they are visible from edge k onward.
  - Latency REQ→GNT is 1 cycle. Then go to GRANT, HOLD_CNT=0, LAST=winner.
  - If EN=0 or REQ=0, stay in IDLE with all outputs idle.
- GRANT (owner O), evaluated each edge, first matching rule wins:
  1. REQ[O]=0 (release), another source requesting, EN=1: hand over to the next RR winner among the other sources at the same edge. No idle bubble; HOLD_CNT=0.
  2. REQ[O]=0 and (no other request, or EN=0): go to IDLE, GNT=000.
  3. REQ[O]=1, HOLD_CNT==MAX_HOLD-1, another source requesting, EN=1: preempt and hand over to the next RR winner; HOLD_CNT=0.
  4. Otherwise: keep O; HOLD_CNT increments, saturating at 2^CNT_W-1.
- A sole requester is never preempted; it holds indefinitely.
- Handover always moves GNT directly between two one-hot values. GNT is never 2 bits hot and never passes through 000 mid-handover.
- MAX_HOLD=1 with contention: ownership rotates every cycle.
- EN deasserted during GRANT: the owner keeps the grant until release. Rule 3 is suppressed.
- Requests are level-sensitive. A REQ pulse shorter than one cycle between edges is not captured.
- Outputs are purely registered; no combinational path from REQ to S/S1.

Decomposition:
- Shared package holds:
  - source index constants SRC_A=0, SRC_B=1, SRC_D=2;
  - select-pair constants SEL_A=2'b11, SEL_B=2'b10, SEL_D=2'b00, SEL_IDLE=2'b00 (ordered {S1,S});
  - state encodings IDLE=1'b0, GRANT=1'b1.
- One sub-module is natural: rr_pick3. It is a combinational 3-way round-robin picker taking REQ masked, LAST and the exclusion mask, and returning the one-hot winner. It is reused by IDLE entry and both handover rules.

Test Plan:
- Reset mid-grant: assert rst while GNT=010 → GNT=000, S=0, S1=0, VALID=0, HOLD_CNT=0 immediately, without waiting for clk.
- After reset, REQ=111 at edge 1 → GNT=001, S1=1, S=1 from edge 1. With MAX_HOLD=4 and REQ held, the sequence is GNT=010 (S1=1,S=0) at edge 5, then 100 (S1=0,S=0) at edge 9, then 001 at edge 13.
- Sole requester: REQ=100 held 40 cycles → GNT stays 100, S1=0, no preemption, HOLD_CNT saturates at 15.
- Release handover: owner A, REQ changes 011→010 → next edge GNT=010 with no 000 cycle; HOLD_CNT=0.
- Release to idle: owner B, REQ 010→000 → next edge GNT=000, VALID=0. A later REQ=101 → GNT=100, because LAST=B gives D priority.
- EN gating: EN=0, REQ=001 from IDLE → GNT stays 000. Owner D with EN dropped and REQ=101 held 10 cycles → D keeps the grant (no preemption).
